// File: rtl/spram_arbiter_pkg.sv
// Shared types and default sizes for the two-requester single-port RAM arbiter.
package spram_pkg;

  localparam int DEF_W        = 8;
  localparam int DEF_D        = 16;
  localparam int DEF_ADDR_LEN = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2,
    ERR   = 2'd3
  } state_t;

  // Command layout at the default sizes; instances with other sizes use the same field order.
  typedef struct packed {
    logic                    wrd;
    logic [DEF_ADDR_LEN-1:0] addr;
    logic [DEF_W-1:0]        wdata;
    logic                    id;
  } cmd_t;

  function automatic logic addr_oor(input int unsigned addr, input int unsigned depth);
    return addr >= depth;
  endfunction

endpackage

// File: rtl/spram_arbiter_if.sv
// Requester-side command/response bundle and the RAM-side command bundle.
interface spram_arbiter_if #(
  parameter int W        = spram_pkg::DEF_W,
  parameter int ADDR_LEN = spram_pkg::DEF_ADDR_LEN
);
  logic                valid;
  logic                ready;
  logic                wrd;
  logic [ADDR_LEN-1:0] addr;
  logic [W-1:0]        wdata;
  logic                rsp_valid;
  logic [W-1:0]        rsp_rdata;
  logic                rsp_err;

  modport master (output valid, wrd, addr, wdata, input ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input valid, wrd, addr, wdata, output ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

interface spram_ram_if #(
  parameter int W        = spram_pkg::DEF_W,
  parameter int ADDR_LEN = spram_pkg::DEF_ADDR_LEN
);
  logic                valid;
  logic                ready;
  logic                wrd;
  logic [ADDR_LEN-1:0] address;
  logic [W-1:0]        wdata;
  logic [W-1:0]        rdata;

  modport master (output valid, wrd, address, wdata, input ready, rdata);
  modport slave  (input valid, wrd, address, wdata, output ready, rdata);
endinterface

// File: rtl/spram_arbiter_rr_arb2.sv
// Two-way grant selector: combinational grant, pointer remembers the last granted requester.
// SPRAM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 always wins, no pointer).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

`ifdef SPRAM_ARB_FIXED_PRIO_EN
  assign grant = {req[1] & ~req[0], req[0]};
`else
  logic ptr_q;

  always_comb begin
    // NOTE: defaulting every always_comb output first keeps the block free of inferred latches.
    grant = 2'b00;
    if (req[0] && req[1]) grant = ptr_q ? 2'b01 : 2'b10;
    else if (req[0])      grant = 2'b01;
    else if (req[1])      grant = 2'b10;
  end

  // Pointer resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    ptr_q <= 1'b1;
    else if (accept && |grant)   ptr_q <= grant[1];
  end
`endif

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port RAM between two requesters; one command in flight at a time.
// Define SPRAM_ARB_FIXED_PRIO_EN for fixed priority to requester 0 instead of round-robin.
module spram_arbiter
  import spram_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int D        = DEF_D,
  parameter int ADDR_LEN = DEF_ADDR_LEN
) (
  input  logic            clk,
  input  logic            rst,
  spram_arbiter_if.slave  req0,
  spram_arbiter_if.slave  req1,
  spram_ram_if.master     ram
);

  typedef struct packed {
    logic                wrd;
    logic [ADDR_LEN-1:0] addr;
    logic [W-1:0]        wdata;
    logic                id;
  } inst_cmd_t;

  state_t           state_q;
  inst_cmd_t        cmd_q;
  inst_cmd_t        sel_cmd;
  logic             ram_valid_q;
  logic [1:0]       rsp_valid_q;
  logic [1:0]       rsp_err_q;
  logic [1:0][W-1:0] rsp_rdata_q;
  logic [1:0]       grant;
  logic             accept;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1.valid, req0.valid}),
    .accept (accept),
    .grant  (grant)
  );

  assign accept     = (state_q == IDLE) && |grant;
  assign req0.ready = (state_q == IDLE) && grant[0];
  assign req1.ready = (state_q == IDLE) && grant[1];

  always_comb begin
    sel_cmd    = '0;
    sel_cmd.id = grant[1];
    if (grant[1]) begin
      sel_cmd.wrd   = req1.wrd;
      sel_cmd.addr  = req1.addr;
      sel_cmd.wdata = req1.wdata;
    end else begin
      sel_cmd.wrd   = req0.wrd;
      sel_cmd.addr  = req0.addr;
      sel_cmd.wdata = req0.wdata;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      ram_valid_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            cmd_q <= sel_cmd;
            if (addr_oor(32'(sel_cmd.addr), D)) begin
              state_q <= ERR;
            end else begin
              state_q     <= ISSUE;
              ram_valid_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (ram.ready) begin
            ram_valid_q <= 1'b0;
            state_q     <= cmd_q.wrd ? IDLE : RDATA;
          end
        end
        RDATA: begin
          rsp_valid_q[cmd_q.id] <= 1'b1;
          rsp_rdata_q[cmd_q.id] <= ram.rdata;
          state_q               <= IDLE;
        end
        ERR: begin
          rsp_valid_q[cmd_q.id] <= 1'b1;
          rsp_err_q[cmd_q.id]   <= 1'b1;
          rsp_rdata_q[cmd_q.id] <= '0;
          state_q               <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram.valid   = ram_valid_q;
  assign ram.wrd     = cmd_q.wrd;
  assign ram.address = cmd_q.addr;
  assign ram.wdata   = cmd_q.wdata;

  assign req0.rsp_valid = rsp_valid_q[0];
  assign req0.rsp_err   = rsp_err_q[0];
  assign req0.rsp_rdata = rsp_rdata_q[0];
  assign req1.rsp_valid = rsp_valid_q[1];
  assign req1.rsp_err   = rsp_err_q[1];
  assign req1.rsp_rdata = rsp_rdata_q[1];

endmodule

// File: tb/tb_spram_arbiter.sv
// Scoreboard bench for spram_arbiter with a behavioural RAM (W=8, D=16, ADDR_LEN=5).
module tb_spram_arbiter;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AL = 5;

  typedef struct {
    logic [W-1:0] rdata;
    logic         err;
  } rsp_t;

  typedef struct {
    logic          wrd;
    logic [AL-1:0] addr;
    logic [W-1:0]  wdata;
    int            edge_no;
  } ram_cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ram_rdy = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  rsp_t     q0[$];
  rsp_t     q1[$];
  int       grant_log[$];
  ram_cmd_t ram_log[$];
  int       ram_valid_cycles = 0;
  int       rsp_cyc[2];
  int       acc_cyc[2];

  logic [W-1:0] mem[D];
  logic [W-1:0] shadow[D];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spram_arbiter_if #(.W(W), .ADDR_LEN(AL)) r0 ();
  spram_arbiter_if #(.W(W), .ADDR_LEN(AL)) r1 ();
  spram_ram_if     #(.W(W), .ADDR_LEN(AL)) ram ();

  spram_arbiter #(.W(W), .D(D), .ADDR_LEN(AL)) dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (r0.slave),
    .req1 (r1.slave),
    .ram  (ram.master)
  );

  assign ram.ready = ram_rdy;

  always @(posedge clk) begin
    if (ram.valid && ram.ready) begin
      if (ram.wrd) mem[ram.address[3:0]] <= ram.wdata;
      else         ram.rdata <= mem[ram.address[3:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (r0.ready) grant_log.push_back(0);
    if (r1.ready) grant_log.push_back(1);
    if (ram.valid) ram_valid_cycles++;
    if (ram.valid && ram.ready)
      ram_log.push_back('{ram.wrd, ram.address, ram.wdata, cyc + 1});
    if (r0.rsp_valid) begin
      rsp_cyc[0] = cyc;
      if (q0.size() == 0) check("rsp0_unexpected", r0.rsp_valid, 1'b0);
      else begin
        e = q0.pop_front();
        check("rsp0_rdata", r0.rsp_rdata, e.rdata);
        check("rsp0_err", r0.rsp_err, e.err);
      end
    end
    if (r1.rsp_valid) begin
      rsp_cyc[1] = cyc;
      if (q1.size() == 0) check("rsp1_unexpected", r1.rsp_valid, 1'b0);
      else begin
        e = q1.pop_front();
        check("rsp1_rdata", r1.rsp_rdata, e.rdata);
        check("rsp1_err", r1.rsp_err, e.err);
      end
    end
  end

  // Present one command, queue its expected response, return #1 after the handshake edge.
  task automatic drive(input int id, input logic wrd, input logic [AL-1:0] addr,
                       input logic [W-1:0] wdata, input bit expect_rsp);
    int   n = 0;
    rsp_t e;
    logic rdy;
    if (id == 0) begin r0.valid = 1'b1; r0.wrd = wrd; r0.addr = addr; r0.wdata = wdata; end
    else         begin r1.valid = 1'b1; r1.wrd = wrd; r1.addr = addr; r1.wdata = wdata; end
    if (expect_rsp && (addr >= D || !wrd)) begin
      e.err   = (addr >= D);
      e.rdata = (addr >= D) ? '0 : shadow[addr[3:0]];
      if (id == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (wrd && addr < D) shadow[addr[3:0]] = wdata;
    forever begin
      @(negedge clk);
      rdy = (id == 0) ? r0.ready : r1.ready;
      if (rdy) break;
      n++;
      if (n > 500) begin
        check("req_ready_timeout", rdy, 1'b1);
        break;
      end
    end
    acc_cyc[id] = cyc + 1;
    @(posedge clk); #1;
    if (id == 0) r0.valid = 1'b0; else r1.valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_pending", q0.size() + q1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int       base;
    ram_cmd_t rc;
    int       exp_g[8];

    for (int i = 0; i < D; i++) begin
      mem[i]    = W'(i * 17);
      shadow[i] = W'(i * 17);
    end
    r0.valid = 1'b0; r0.wrd = 1'b0; r0.addr = '0; r0.wdata = '0;
    r1.valid = 1'b0; r1.wrd = 1'b0; r1.addr = '0; r1.wdata = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_ram_valid", ram.valid, 1'b0);
    check("rst_ram_address", ram.address, 0);
    check("rst_rsp0_valid", r0.rsp_valid, 1'b0);
    check("rst_rsp1_valid", r1.rsp_valid, 1'b0);
    check("rst_rsp0_rdata", r0.rsp_rdata, 0);
    @(posedge clk); #1;

    // Write addr 3 = 0xA5
    base = ram_valid_cycles;
    ram_log.delete();
    drive(0, 1'b1, 5'd3, 8'hA5, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("wr_ram_valid_cycles", ram_valid_cycles - base, 1);
    check("wr_ram_hs_count", ram_log.size(), 1);
    if (ram_log.size() != 0) begin
      rc = ram_log.pop_front();
      check("wr_ram_wrd", rc.wrd, 1'b1);
      check("wr_ram_addr", rc.addr, 3);
      check("wr_ram_wdata", rc.wdata, 8'hA5);
      check("wr_ram_hs_edge", rc.edge_no, acc_cyc[0] + 1);
    end

    // Read addr 3 back
    ram_log.delete();
    drive(0, 1'b0, 5'd3, 8'h00, 1'b1);
    drain();
    check("rd_latency", rsp_cyc[0], acc_cyc[0] + 2);
    check("rd_ram_hs_count", ram_log.size(), 1);
    if (ram_log.size() != 0) begin
      rc = ram_log.pop_front();
      check("rd_ram_wrd", rc.wrd, 1'b0);
      check("rd_ram_addr", rc.addr, 3);
    end
    @(posedge clk); #1;

    // Contention from reset
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    grant_log.delete();
    fork
      begin for (int i = 0; i < 4; i++) drive(0, 1'b0, 5'd3, 8'h00, 1'b1); end
      begin for (int i = 0; i < 4; i++) drive(1, 1'b0, 5'd5, 8'h00, 1'b1); end
    join
    drain();
`ifdef SPRAM_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    check("rr_grant_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check($sformatf("rr_grant_%0d", i), grant_log[i], exp_g[i]);
    @(posedge clk); #1;

    // Read with RAM stalled for 4 cycles
    base = ram_valid_cycles;
    ram_rdy = 1'b0;
    drive(1, 1'b0, 5'd7, 8'h00, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("stall_ram_valid", ram.valid, 1'b1);
      check("stall_ram_address", ram.address, 7);
      check("stall_ram_wrd", ram.wrd, 1'b0);
    end
    @(posedge clk); #1 ram_rdy = 1'b1;
    drain();
    check("stall_ram_valid_cycles", ram_valid_cycles - base, 5);
    check("stall_rsp_latency", rsp_cyc[1], acc_cyc[1] + 6);
    @(posedge clk); #1;

    // Out-of-range write from requester 1
    base = ram_valid_cycles;
    drive(1, 1'b1, 5'd16, 8'h3C, 1'b1);
    drain();
    check("err_no_ram_valid", ram_valid_cycles - base, 0);
    check("err_latency", rsp_cyc[1], acc_cyc[1] + 1);
    @(posedge clk); #1;

    // Reset while a command is issuing
    ram_rdy = 1'b0;
    drive(0, 1'b0, 5'd2, 8'h00, 1'b0);
    @(negedge clk);
    check("issue_ram_valid", ram.valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_ram_valid", ram.valid, 1'b0);
    check("rst_async_rsp0_rdata", r0.rsp_rdata, 0);
    @(posedge clk); #1 rst = 1'b1;
    ram_rdy = 1'b1;
    grant_log.delete();
    fork
      drive(0, 1'b0, 5'd4, 8'h00, 1'b1);
      drive(1, 1'b0, 5'd6, 8'h00, 1'b1);
    join
    drain();
    check("post_rst_grant_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("post_rst_first_grant", grant_log[0], 0);
      check("post_rst_second_grant", grant_log[1], 1);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
